pc_seq_unit: RTL and testbench
==============================

PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning Count/Target bit width.
REQ-002 SHALL have parameter STEP, default 1, meaning sequential increment added to Count.
REQ-003 SHALL have parameter RESET_VEC, default 0, meaning Count value after reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address stack entries (power of two, >=2).
REQ-005 SHALL have one clock; reset is synchronous and active-low.
REQ-006 SHALL have port CLK  input  1  rising-edge clock.
REQ-007 SHALL have port Init_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port Halt  input  1  request to enter HALTED.
REQ-009 SHALL have port Resume  input  1  request to leave HALTED.
REQ-010 SHALL have port Stall  input  1  hold Count this cycle (RUN only).
REQ-011 SHALL have port Branch  input  1  load Target.
REQ-012 SHALL have port Call  input  1  push return address, load Target.
REQ-013 SHALL have port Ret  input  1  pop stack into Count.
REQ-014 SHALL have port Target  input  WIDTH  branch/call destination.
REQ-015 SHALL have port Count  output  WIDTH  registered program counter.
REQ-016 SHALL have port Halted  output  1  registered, high in HALTED state.
REQ-017 SHALL have port RasEmpty  output  1  stack holds no entries.
REQ-018 SHALL have port RasFull  output  1  stack holds RAS_DEPTH entries.
REQ-019 SHALL have port RasErr  output  1  sticky overflow/underflow flag.

Function
REQ-020 SHALL implement two states, RUN and HALTED; all updates on CLK rising edge, Count changes one cycle after the controlling input is sampled.
REQ-021 In RUN, per-cycle priority SHALL be: Halt > Stall > Ret > Call > Branch > Count+STEP.
REQ-022 Halt=1 in RUN SHALL hold Count, set Halted, go HALTED; no stack change.
REQ-023 In HALTED, Count and stack SHALL hold regardless of Stall/Branch/Call/Ret.
REQ-024 HALTED SHALL go RUN when Resume=1 and Halt=0; Count holds that cycle, normal operation from next cycle.
REQ-025 Stall=1 SHALL hold Count and stack.
REQ-026 Branch SHALL load Count<=Target.
REQ-027 Call SHALL push Count+STEP and load Count<=Target.
REQ-028 Call when full SHALL discard the oldest entry, push the new one, set RasErr; RasFull stays 1.
REQ-029 Ret when non-empty SHALL load Count<=top entry and pop.
REQ-030 Ret when empty SHALL execute Count+STEP and set RasErr.
REQ-031 Ret and Call in the same cycle SHALL perform Ret only; Call ignored.
REQ-032 All Count arithmetic SHALL be modulo 2^WIDTH (max value + STEP wraps, no flag).
REQ-033 RasErr SHALL remain set until reset.

Reset
REQ-034 Init_n=0 at a CLK edge SHALL override all inputs, in any state.
REQ-035 Reset SHALL give Count=RESET_VEC, Halted=0, state RUN, stack emptied, RasEmpty=1, RasFull=0, RasErr=0.
REQ-036 Reset asserted mid-Call/Ret or in HALTED SHALL leave no residual stack entries.

Configuration
REQ-037 Macro PC_RAS_EN SHALL compile in the return-address stack per REQ-027..REQ-031.
REQ-038 Without PC_RAS_EN: Call SHALL behave as Branch; Ret SHALL be treated as no request; RasEmpty=1, RasFull=0, RasErr=0 constantly; no stack storage.

Verification
REQ-039 Reset then 3 free-run cycles, defaults -> Count 0,1,2,3; Halted=0; RasEmpty=1.
REQ-040 Count=16'hFFFF, no requests -> next Count=16'h0000, no error.
REQ-041 Count=16'h0010, Call Target=16'h0100; 2 cycles; Ret -> Count 0100,0101,0102,0011; RasEmpty ends 1.
REQ-042 Five nested Calls, RAS_DEPTH=4 -> RasFull=1, RasErr=1; four Rets return the four newest addresses; fifth Ret -> Count+1.
REQ-043 Halt at Count=16'h0020 with Branch -> Count holds 0020, Halted=1; Resume -> 0020 one more cycle, then 0021.
REQ-044 Init_n=0 while HALTED with two stack entries -> Count=RESET_VEC, Halted=0, RasEmpty=1, RasErr=0.

Source files
------------

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter sequencer with RUN/HALTED control and an
// optional return-address stack (compiled in when PC_RAS_EN is defined).
// Without PC_RAS_EN, Call acts as Branch, Ret is ignored and the stack
// flags are tied to their empty/clear values.
module pc_seq_unit #(
  parameter int WIDTH     = 16,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Init_n,
  input  logic             Halt,
  input  logic             Resume,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] Count,
  output logic             Halted,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasErr
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VEC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic [WIDTH-1:0] seq_pc_s;

`ifdef PC_RAS_EN
  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);

  // Circular buffer: ras_ptr_q is the next write slot, top is ras_ptr_q-1.
  // Pushing while full overwrites the slot at ras_ptr_q, which is the oldest.
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
  logic [PTR_W-1:0] ras_top_s;
  logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
  logic             ras_err_q, ras_err_d;
  logic             ras_empty_q, ras_empty_d;
  logic             ras_full_q, ras_full_d;
`else
  logic             unused_cfg_s;
  assign unused_cfg_s = Ret ^ RAS_DEPTH[0];
`endif

  // Next-state computation: RUN priority Halt > Stall > Ret > Call > Branch > +STEP
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    halted_d = halted_q;
    seq_pc_s = count_q + STEP_V;
`ifdef PC_RAS_EN
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_err_d = ras_err_q;
    ras_top_s = ras_ptr_q - PTR_W'(1);
`endif
    case (state_q)
      ST_RUN: begin
        if (Halt) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else if (Stall) begin
          count_d = count_q;
`ifdef PC_RAS_EN
        end else if (Ret) begin
          if (ras_cnt_q != {CNT_W{1'b0}}) begin
            count_d   = ras_mem_q[ras_top_s];
            ras_ptr_d = ras_top_s;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
          end else begin
            count_d   = seq_pc_s;
            ras_err_d = 1'b1;
          end
        end else if (Call) begin
          ras_mem_d[ras_ptr_q] = seq_pc_s;
          ras_ptr_d            = ras_ptr_q + PTR_W'(1);
          count_d              = Target;
          if (ras_cnt_q == DEPTH_V) begin
            ras_cnt_d = ras_cnt_q;
            ras_err_d = 1'b1;
          end else begin
            ras_cnt_d = ras_cnt_q + CNT_W'(1);
          end
`endif
        end else if (Branch || Call) begin
          count_d = Target;
        end else begin
          count_d = seq_pc_s;
        end
      end
      ST_HALTED: begin
        if (Resume && !Halt) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end else begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        halted_d = 1'b0;
      end
    endcase
`ifdef PC_RAS_EN
    ras_empty_d = (ras_cnt_d == {CNT_W{1'b0}});
    ras_full_d  = (ras_cnt_d == DEPTH_V);
`endif
  end

  // State, counter and stack registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      state_q  <= ST_RUN;
      count_q  <= RESET_V;
      halted_q <= 1'b0;
`ifdef PC_RAS_EN
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= {WIDTH{1'b0}};
      end
      ras_ptr_q   <= {PTR_W{1'b0}};
      ras_cnt_q   <= {CNT_W{1'b0}};
      ras_err_q   <= 1'b0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      halted_q <= halted_d;
`ifdef PC_RAS_EN
      ras_mem_q   <= ras_mem_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_err_q   <= ras_err_d;
      ras_empty_q <= ras_empty_d;
      ras_full_q  <= ras_full_d;
`endif
    end
  end

  assign Count  = count_q;
  assign Halted = halted_q;
`ifdef PC_RAS_EN
  assign RasEmpty = ras_empty_q;
  assign RasFull  = ras_full_q;
  assign RasErr   = ras_err_q;
`else
  assign RasEmpty = 1'b1;
  assign RasFull  = 1'b0;
  assign RasErr   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed literal sequences plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_pc_seq_unit;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Init_n, Halt, Resume, Stall, Branch, Call, Ret;
  logic [15:0] Target;
  logic [15:0] Count;
  logic        Halted, RasEmpty, RasFull, RasErr;

  pc_seq_unit dut (
    .CLK(CLK), .Init_n(Init_n), .Halt(Halt), .Resume(Resume), .Stall(Stall),
    .Branch(Branch), .Call(Call), .Ret(Ret), .Target(Target),
    .Count(Count), .Halted(Halted), .RasEmpty(RasEmpty), .RasFull(RasFull),
    .RasErr(RasErr)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [15:0] m_pc;
  bit          m_halted;
  bit          m_err;
  logic [15:0] m_stk[$];
  bit          chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock using the rules of the sequencer
  task automatic model_step();
    if (!Init_n) begin
      m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0; m_stk.delete();
    end else if (m_halted) begin
      if (Resume && !Halt) m_halted = 1'b0;
    end else if (Halt) begin
      m_halted = 1'b1;
    end else if (Stall) begin
      m_pc = m_pc;
    end else if (RAS_EN && Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
    end else if (RAS_EN && Call) begin
      if (m_stk.size() == DEPTH) begin
        void'(m_stk.pop_front());
        m_err = 1'b1;
      end
      m_stk.push_back(m_pc + 16'd1);
      m_pc = Target;
    end else if (Branch || Call) begin
      m_pc = Target;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic step(input bit i_n, input bit h, input bit rs, input bit st,
                      input bit br, input bit ca, input bit rt, input logic [15:0] t);
    Init_n = i_n; Halt = h; Resume = rs; Stall = st;
    Branch = br; Call = ca; Ret = rt; Target = t;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle(); step(1, 0, 0, 0, 0, 0, 0, 16'h0000); endtask
  task automatic rst();  step(0, 0, 0, 0, 0, 0, 0, 16'h0000); endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("count",     Count,            m_pc);
      chk("halted",    {15'd0, Halted},   {15'd0, m_halted});
      chk("ras_empty", {15'd0, RasEmpty}, {15'd0, (m_stk.size() == 0)});
      chk("ras_full",  {15'd0, RasFull},  {15'd0, (m_stk.size() == DEPTH)});
      chk("ras_err",   {15'd0, RasErr},   {15'd0, m_err});
    end
  end

  logic [15:0] exp_ret [5];
  logic [15:0] exp_after_ret;

  initial begin
    Init_n = 1'b0; Halt = 1'b0; Resume = 1'b0; Stall = 1'b0;
    Branch = 1'b0; Call = 1'b0; Ret = 1'b0; Target = 16'h0000;
    m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0;

    // Reset then free-run
    rst();
    chk_en = 1'b1;
    rst();
    chk("lit_reset_count", Count, 16'h0000);
    chk("lit_reset_halted", {15'd0, Halted}, 16'd0);
    chk("lit_reset_empty", {15'd0, RasEmpty}, 16'd1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("lit_freerun", Count, 16'(i));
    end

    // Wrap at max value
    step(1, 0, 0, 0, 1, 0, 0, 16'hFFFF);
    chk("lit_branch_ffff", Count, 16'hFFFF);
    idle();
    chk("lit_wrap", Count, 16'h0000);
    chk("lit_wrap_err", {15'd0, RasErr}, 16'd0);

    // Call / Ret
    step(1, 0, 0, 0, 1, 0, 0, 16'h0010);
    step(1, 0, 0, 0, 0, 1, 0, 16'h0100);
    chk("lit_call", Count, 16'h0100);
    idle(); chk("lit_call_p1", Count, 16'h0101);
    idle(); chk("lit_call_p2", Count, 16'h0102);
    step(1, 0, 0, 0, 0, 0, 1, 16'h0000);
    exp_after_ret = RAS_EN ? 16'h0011 : 16'h0103;
    chk("lit_ret", Count, exp_after_ret);
    chk("lit_ret_empty", {15'd0, RasEmpty}, 16'd1);

    // Five nested calls into a four-deep stack
    rst();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 1, 0, 16'(i * 16'h1000));
    chk("lit_nest_full", {15'd0, RasFull}, {15'd0, RAS_EN});
    chk("lit_nest_err",  {15'd0, RasErr},  {15'd0, RAS_EN});
    if (RAS_EN) begin
      exp_ret = '{16'h4001, 16'h3001, 16'h2001, 16'h1001, 16'h1002};
    end else begin
      exp_ret = '{16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005};
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 16'h0000);
      chk("lit_nest_ret", Count, exp_ret[i]);
    end

    // Halt with Branch, hold while halted, resume
    step(1, 0, 0, 0, 1, 0, 0, 16'h0020);
    step(1, 1, 0, 0, 1, 0, 0, 16'h0999);
    chk("lit_halt_count", Count, 16'h0020);
    chk("lit_halt_flag", {15'd0, Halted}, 16'd1);
    step(1, 0, 0, 1, 1, 1, 1, 16'h0777);
    chk("lit_halted_hold", Count, 16'h0020);
    step(1, 1, 1, 0, 0, 0, 0, 16'h0000);
    chk("lit_resume_blocked", {15'd0, Halted}, 16'd1);
    step(1, 0, 1, 0, 0, 0, 0, 16'h0000);
    chk("lit_resume_count", Count, 16'h0020);
    chk("lit_resume_flag", {15'd0, Halted}, 16'd0);
    idle();
    chk("lit_resume_next", Count, 16'h0021);

    // Reset while halted with stack entries and a pending error
    step(1, 0, 0, 0, 0, 0, 1, 16'h0000);
    step(1, 0, 0, 0, 0, 1, 0, 16'h0200);
    step(1, 0, 0, 0, 0, 1, 0, 16'h0300);
    step(1, 1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 0, 1, 1, 16'h0400);
    chk("lit_rst_halt_count", Count, 16'h0000);
    chk("lit_rst_halt_flag", {15'd0, Halted}, 16'd0);
    chk("lit_rst_halt_empty", {15'd0, RasEmpty}, 16'd1);
    chk("lit_rst_halt_err", {15'd0, RasErr}, 16'd0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] t;
      t = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                      : 16'($urandom);
      step($urandom_range(0, 63) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           t);
    end

    chk_en = 1'b0;
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
